// File: rtl/game_pkg.sv
// Shared encodings and helpers for the game round controller and the
// downstream scoring stage.
package game_pkg;

   localparam int SCORE_W = 8;
   localparam int ID_W    = 3;
   localparam int CTRL_W  = 3;
   localparam int TIME_W  = 7;

   // Command word seen by the scoring / score RAM stage; 5..7 are never driven.
   typedef enum logic [CTRL_W-1:0] {
      IDLE   = 3'd0,
      NEW    = 3'd1,
      PLAY   = 3'd2,
      COMMIT = 3'd3,
      SHOW   = 3'd4
   } ctrl_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READY  = 3'd1,
      S_PLAY   = 3'd2,
      S_COMMIT = 3'd3,
      S_SHOW   = 3'd4
   } state_t;

   // Applies a hit and/or miss to the current score. The arithmetic is done
   // in a wide signed integer so neither the floor at 0 nor the ceiling at
   // maxScore can wrap.
   function automatic logic [SCORE_W-1:0] satScore(
      input logic [SCORE_W-1:0] cur,
      input logic               addHit,
      input logic               subMiss,
      input int                 hitPts,
      input int                 missPts,
      input int                 maxScore
   );
      int sum;
      sum = int'(cur);
      if (addHit)  sum = sum + hitPts;
      if (subMiss) sum = sum - missPts;
      if (sum < 0)        sum = 0;
      if (sum > maxScore) sum = maxScore;
      return SCORE_W'(sum);
   endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button conditioner: 2-flop synchronizer followed by a registered
// rising-edge detector. One press gives one single-cycle pulse, three clocks
// after the raw edge.
module btn_pulse (
   input  logic clk,
   input  logic rst,
   input  logic rawIn,
   output logic pulse
);

   logic [1:0] syncReg;
   logic       prevReg;
   logic [2:0] warmReg;

   // Synchronize the raw level; prevReg remembers the previous synced level.
   // warmReg holds off the detector until prevReg carries a real sample, so a
   // button held down through reset never looks like a fresh press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         syncReg <= 2'b00;
         prevReg <= 1'b0;
         warmReg <= 3'b000;
         pulse   <= 1'b0;
      end else begin
         syncReg <= {syncReg[0], rawIn};
         prevReg <= syncReg[1];
         warmReg <= {warmReg[1:0], 1'b1};
         pulse   <= warmReg[2] & syncReg[1] & ~prevReg;
      end
   end

endmodule

// File: rtl/game_score_ctrl.sv
// Timed game round controller: conditions the start/hit/miss buttons, runs
// the round timer, accumulates a saturating score and drives the command
// word, player identity and score to the downstream scoring stage.
module game_score_ctrl
   import game_pkg::*;
#(
   parameter int ROUND_SECS = 30,
   parameter int HIT_PTS    = 3,
   parameter int MISS_PTS   = 1,
   parameter int MAX_SCORE  = 99
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sec_tick,
   input  logic               start_btn,
   input  logic               hit_btn,
   input  logic               miss_btn,
   input  logic               login_valid,
   input  logic [ID_W-1:0]    login_id,
   input  logic               login_guest,
   output logic [CTRL_W-1:0]  controlSig,
   output logic               isGuest,
   output logic [ID_W-1:0]    intIDout,
   output logic [SCORE_W-1:0] score,
   output logic [TIME_W-1:0]  time_left
);

   localparam logic [TIME_W-1:0] ROUND_INIT = TIME_W'(ROUND_SECS);

   state_t     stateReg;
   logic [2:0] rawBtn;
   logic [2:0] btnPulse;
   logic       startP;
   logic       hitP;
   logic       missP;

   assign rawBtn = {miss_btn, hit_btn, start_btn};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : gBtn
         btn_pulse uBtn (
            .clk   (clk),
            .rst   (rst),
            .rawIn (rawBtn[gi]),
            .pulse (btnPulse[gi])
         );
      end
   endgenerate

   assign startP = btnPulse[0];
   assign hitP   = btnPulse[1];
   assign missP  = btnPulse[2];

   // Round FSM with registered outputs. controlSig is loaded on the edge that
   // enters a state, so NEW and COMMIT each last exactly one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateReg   <= S_IDLE;
         controlSig <= IDLE;
         isGuest    <= 1'b0;
         intIDout   <= '0;
         score      <= '0;
         time_left  <= '0;
      end else begin
         case (stateReg)
            S_IDLE: begin
               controlSig <= IDLE;
               if (login_valid) begin
                  intIDout <= login_id;
                  isGuest  <= login_guest;
                  stateReg <= S_READY;
               end
            end

            S_READY: begin
               controlSig <= IDLE;
               if (login_valid) begin
                  intIDout <= login_id;
                  isGuest  <= login_guest;
               end
               if (startP) begin
                  score      <= '0;
                  time_left  <= ROUND_INIT;
                  controlSig <= NEW;
                  stateReg   <= S_PLAY;
               end
            end

            S_PLAY: begin
               controlSig <= PLAY;
               if (hitP || missP) begin
                  score <= satScore(score, hitP, missP, HIT_PTS, MISS_PTS, MAX_SCORE);
               end
               if (sec_tick) begin
                  if (time_left <= TIME_W'(1)) begin
                     time_left  <= '0;
                     controlSig <= COMMIT;
                     stateReg   <= S_COMMIT;
                  end else begin
                     time_left <= time_left - TIME_W'(1);
                  end
               end
            end

            S_COMMIT: begin
               controlSig <= SHOW;
               stateReg   <= S_SHOW;
            end

            S_SHOW: begin
               controlSig <= SHOW;
               if (login_valid) begin
                  intIDout   <= login_id;
                  isGuest    <= login_guest;
                  score      <= '0;
                  controlSig <= IDLE;
                  stateReg   <= S_READY;
               end else if (startP) begin
                  score      <= '0;
                  time_left  <= ROUND_INIT;
                  controlSig <= NEW;
                  stateReg   <= S_PLAY;
               end
            end

            default: begin
               controlSig <= IDLE;
               stateReg   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
